ad9739_dly_ctrl: RTL

//  Sequencer for the AD9739 LVDS output-delay taps. Takes tap-write or tap-sweep requests over a

---
 rtl/ad9739_dly_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ad9739_dly_ctrl.sv
`timescale 1ns/1ps
// AD9739 LVDS delay-tap sequencer: loads taps, verifies readback with bounded retry, optional 0..31 sweep.
// Single write: dly_load one cycle after handshake, status SETTLE_CYCLES+2 cycles later; cfg_ready only in IDLE, no queuing.
module ad9739_dly_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRY     = 3,
  parameter int DWELL_CYCLES  = 1024
) (
  input  logic       dac_clk,
  input  logic       dac_rstn,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       cfg_sweep,
  input  logic [9:0] cfg_tap,
  output logic       dly_load,
  output logic [9:0] dly_cin,
  input  logic [9:0] dly_cout,
  output logic       busy,
  output logic       stat_done,
  output logic       stat_err,
  output logic [9:0] stat_tap,
  output logic       sweep_step
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DWELL  = 3'd4;

  localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int DWELL_LAST  = (DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0;
  localparam int CNT_MAX     = (SETTLE_LAST > DWELL_LAST) ? SETTLE_LAST : DWELL_LAST;
  localparam int CW          = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_LAST);
  localparam logic [CW-1:0] DWELL_INIT  = CW'(DWELL_LAST);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [9:0]    TAP_END     = 10'h3FF;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          sweep_q, sweep_d;
  logic [9:0]    tap_d;
  logic [9:0]    stat_tap_d;
  logic          done_d, err_d, step_d;

  // Each lane saturates at 31 so a lane can never wrap back to tap 0.
  function automatic logic [9:0] tap_next(input logic [9:0] t);
    logic [4:0] lane_a;
    logic [4:0] lane_b;
    lane_a = (t[4:0] == 5'd31) ? t[4:0] : t[4:0] + 5'd1;
    lane_b = (t[9:5] == 5'd31) ? t[9:5] : t[9:5] + 5'd1;
    return {lane_b, lane_a};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    sweep_d    = sweep_q;
    tap_d      = dly_cin;
    stat_tap_d = stat_tap;
    done_d     = 1'b0;
    err_d      = 1'b0;
    step_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          tap_d   = cfg_sweep ? 10'h000 : cfg_tap;
          sweep_d = cfg_sweep;
          retry_d = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d   = SETTLE_INIT;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_CHECK: begin
        stat_tap_d = dly_cout;
        if (dly_cout == dly_cin) begin
          if (sweep_q) begin
            cnt_d   = DWELL_INIT;
            step_d  = (DWELL_INIT == '0);
            state_d = ST_DWELL;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + RW'(1);
          state_d = ST_LOAD;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DWELL: begin
        if (cnt_q == '0) begin
          if (dly_cin == TAP_END) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tap_d   = tap_next(dly_cin);
            retry_d = '0;
            state_d = ST_LOAD;
          end
        end else begin
          cnt_d  = cnt_q - CW'(1);
          // Registered pulse lands in the final dwell cycle.
          step_d = (cnt_q == CW'(1));
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      sweep_q    <= 1'b0;
      dly_cin    <= 10'h000;
      dly_load   <= 1'b0;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
      stat_done  <= 1'b0;
      stat_err   <= 1'b0;
      stat_tap   <= 10'h000;
      sweep_step <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      sweep_q    <= sweep_d;
      dly_cin    <= tap_d;
      dly_load   <= (state_d == ST_LOAD);
      cfg_ready  <= (state_d == ST_IDLE);
      busy       <= (state_d != ST_IDLE);
      stat_done  <= done_d;
      stat_err   <= err_d;
      stat_tap   <= stat_tap_d;
      sweep_step <= step_d;
    end
  end

endmodule
